uart_cmd_parser: RTL
====================

# uart_cmd_parser

- Register-access command engine directly downstream of the UART block.
- Pops framed command bytes from the UART RX FIFO, validates them and issues single-cycle register write/read strobes on the local register bus.
- Pushes ACK/NAK and read-data bytes back into the UART TX FIFO.
- Sits between the UART and the driver's control register file.

## Interface

Parameters:
- BITLEN, 8, byte width. Also the register address and data width.
- SYNC_BYTE, 8'hA5, frame start marker.
- BYTE_TIMEOUT, 1_000_000, maximum clk cycles allowed between consecutive frame bytes.
- RD_TIMEOUT, 255, maximum clk cycles to wait for reg_rd_valid.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rstb  in  1  reset, asynchronous, active-high.
- rx_data  in  BITLEN  head of RX FIFO. Valid whenever rx_empty=0 (first-word-fall-through).
- rx_empty  in  1  RX FIFO empty.
- rx_read  out  1  pops one RX byte. Asserted only when rx_empty=0.
- tx_data  out  BITLEN  byte to TX FIFO.
- tx_full  in  1  TX FIFO full.
- tx_write  out  1  pushes tx_data. Asserted only when tx_full=0.
- reg_addr  out  BITLEN  register address, held from ADDR capture until the next frame.
- reg_wdata  out  BITLEN  write data.
- reg_wr  out  1  single-cycle write strobe.
- reg_rd  out  1  single-cycle read strobe.
- reg_rdata  in  BITLEN  read data, valid with reg_rd_valid.
- reg_rd_valid  in  1  read completion; at least 1 cycle after reg_rd.
- frame_err  out  1  single-cycle pulse on checksum error, bad opcode, byte timeout or read timeout.
- busy  out  1  high in every state except IDLE.

## Operation

Frame format:
- Read frame: SYNC, OP, ADDR, CHK.
- Write frame: SYNC, OP, ADDR, DATA, CHK.
- OP 8'h01 = write, 8'h02 = read.
- CHK = XOR of OP, ADDR and (write only) DATA.

States and transitions:
- IDLE: pop each available byte. SYNC_BYTE -> OP. Any other byte is discarded silently, with no error.
- OP: pop and capture. 01/02 -> ADDR. Other values -> frame_err, then RESP with NAK.
- ADDR: pop and capture. Write -> DATA; read -> CHK.
- DATA: pop and capture -> CHK.
- CHK: pop and compare.
  - Mismatch -> frame_err, RESP with NAK.
  - Match and write -> EXEC_WR.
  - Match and read -> EXEC_RD.
- EXEC_WR: reg_wr high for one cycle -> RESP with ACK (8'h06).
- EXEC_RD: reg_rd high for one cycle -> WAIT_RD.
- WAIT_RD: on reg_rd_valid, latch reg_rdata -> RESP with ACK followed by the data byte. After RD_TIMEOUT cycles -> frame_err, RESP with NAK (8'h15).
- RESP: write each queued byte (1 or 2) when tx_full=0 -> IDLE after the last byte. Stalls indefinitely while tx_full=1; no timeout in RESP.

Byte timeout:
- A counter runs in OP, ADDR, DATA and CHK. It clears on every pop.
- Reaching BYTE_TIMEOUT -> frame_err, IDLE, with no response byte.

Ordering and concurrency:
- A SYNC_BYTE inside a frame is treated as ordinary data (no resync).
- Only one frame is in flight. RX bytes are not popped in EXEC_*, WAIT_RD or RESP.

Reset:
- All outputs 0, state IDLE, counters 0, captured registers 0.
- Reset mid-frame or mid-response drops the frame. Bytes already pushed to TX stay in the TX FIFO.

## Timing

Handshakes:
- rx_read is combinational from state and rx_empty. At most one pop per cycle; rx_data is sampled in the same cycle rx_read=1.
- tx_write is registered, with tx_data stable in the same cycle. tx_full is checked in the cycle before assertion.

Latencies:
- Back-to-back bytes: one state per byte per cycle.
- Write: reg_wr is asserted 1 cycle after the CHK pop. ACK tx_write follows 1 cycle after reg_wr when tx_full=0.
- Read: reg_rd is asserted 1 cycle after the CHK pop. The first tx_write follows 1 cycle after reg_rd_valid.

Invariants:
- reg_wr and reg_rd are never high together.
- reg_addr and reg_wdata are stable from the strobe cycle through RESP.

Counters:
- BYTE_TIMEOUT counter width is $clog2(BYTE_TIMEOUT+1); RD_TIMEOUT counter width is $clog2(RD_TIMEOUT+1). Both saturate.
- frame_err fires once per timeout event.

## Test plan

- Write: RX A5 01 10 3C 2D -> reg_wr pulse with addr=8'h10, wdata=8'h3C. TX 06. No frame_err.
- Read: RX A5 02 20 22; reg_rd_valid 3 cycles after reg_rd with rdata=8'h5A -> TX 06 then 5A.
- Bad checksum: RX A5 01 10 3C 00 -> no reg_wr, one frame_err pulse, TX 15.
- Garbage and timeout:
  - RX 00 FF A5 02 (then silent; BYTE_TIMEOUT=100) -> leading bytes dropped silently.
  - frame_err pulses 100 cycles after the last pop, with no TX byte.
  - A following valid read completes normally.
- Read timeout and TX backpressure:
  - Valid read with reg_rd_valid never asserted, RD_TIMEOUT=255 -> frame_err at cycle 255, then TX 15.
  - Repeat with tx_full=1 for 50 cycles -> tx_write is held off, and the byte is pushed once tx_full drops.
- Reset mid-frame: assert rstb after A5 01 -> outputs 0 immediately (async). Next full write frame succeeds.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed register-access command engine between the UART FIFOs and a register bus
// Frames are SYNC OP ADDR [DATA] CHK; replies are ACK, ACK + read data, or NAK.
module uart_cmd_parser #(
  parameter int                BITLEN       = 8,
  parameter logic [BITLEN-1:0] SYNC_BYTE    = BITLEN'(8'hA5),
  parameter int                BYTE_TIMEOUT = 1_000_000,
  parameter int                RD_TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [BITLEN-1:0] rx_data,
  input  logic              rx_empty,
  output logic              rx_read,
  output logic [BITLEN-1:0] tx_data,
  input  logic              tx_full,
  output logic              tx_write,
  output logic [BITLEN-1:0] reg_addr,
  output logic [BITLEN-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [BITLEN-1:0] reg_rdata,
  input  logic              reg_rd_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int RT_W = $clog2(RD_TIMEOUT + 1);

  localparam logic [BITLEN-1:0] OP_WR = BITLEN'(8'h01);
  localparam logic [BITLEN-1:0] OP_RD = BITLEN'(8'h02);
  localparam logic [BITLEN-1:0] ACK   = BITLEN'(8'h06);
  localparam logic [BITLEN-1:0] NAK   = BITLEN'(8'h15);

  typedef enum logic [3:0] {
    S_IDLE,
    S_OP,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EXEC_WR,
    S_EXEC_RD,
    S_WAIT_RD,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BITLEN-1:0] op_q;
  logic [BITLEN-1:0] addr_q;
  logic [BITLEN-1:0] wdata_q;
  logic [BT_W-1:0]   byte_cnt;
  logic [RT_W-1:0]   rd_cnt;
  logic [1:0]        q_n;
  logic [BITLEN-1:0] q0;
  logic [BITLEN-1:0] q1;
  logic              tx_write_q;
  logic [BITLEN-1:0] tx_data_q;
  logic              frame_err_q;

  logic              in_frame;
  logic              is_wr;
  logic [BITLEN-1:0] chk_exp;
  logic              byte_to;
  logic              rd_to;
  logic              err;
  logic              load;
  logic [1:0]        load_n;
  logic [BITLEN-1:0] load_b0;
  logic [BITLEN-1:0] load_b1;
  logic [1:0]        qn_eff;
  logic [BITLEN-1:0] q0_eff;
  logic [BITLEN-1:0] q1_eff;
  logic              push;

  assign in_frame = (state == S_OP) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  // Gated by reset so nothing is popped while the frame state is being cleared.
  assign rx_read  = (in_frame || state == S_IDLE) && !rx_empty && !rstb;
  assign is_wr    = (op_q == OP_WR);
  assign chk_exp  = op_q ^ addr_q ^ (is_wr ? wdata_q : '0);
  assign byte_to  = in_frame && !rx_read && (byte_cnt == BT_W'(BYTE_TIMEOUT - 1));
  assign rd_to    = (state == S_WAIT_RD) && !reg_rd_valid && (rd_cnt == RT_W'(RD_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    load      = 1'b0;
    load_n    = 2'd0;
    load_b0   = '0;
    load_b1   = '0;
    case (state)
      S_IDLE: begin
        if (rx_read && rx_data == SYNC_BYTE) state_nxt = S_OP;
      end
      S_OP: begin
        if (rx_read) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            state_nxt = S_ADDR;
          end else begin
            err       = 1'b1;
            state_nxt = S_RESP;
            load      = 1'b1;
            load_n    = 2'd1;
            load_b0   = NAK;
          end
        end
      end
      S_ADDR: begin
        if (rx_read) state_nxt = is_wr ? S_DATA : S_CHK;
      end
      S_DATA: begin
        if (rx_read) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (rx_read) begin
          if (rx_data != chk_exp) begin
            err       = 1'b1;
            state_nxt = S_RESP;
            load      = 1'b1;
            load_n    = 2'd1;
            load_b0   = NAK;
          end else begin
            state_nxt = is_wr ? S_EXEC_WR : S_EXEC_RD;
          end
        end
      end
      S_EXEC_WR: begin
        state_nxt = S_RESP;
        load      = 1'b1;
        load_n    = 2'd1;
        load_b0   = ACK;
      end
      S_EXEC_RD: begin
        state_nxt = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (reg_rd_valid) begin
          state_nxt = S_RESP;
          load      = 1'b1;
          load_n    = 2'd2;
          load_b0   = ACK;
          load_b1   = reg_rdata;
        end else if (rd_to) begin
          err       = 1'b1;
          state_nxt = S_RESP;
          load      = 1'b1;
          load_n    = 2'd1;
          load_b0   = NAK;
        end
      end
      S_RESP: begin
        if (q_n == 2'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A silent line mid-frame abandons the frame without any reply.
    if (byte_to) begin
      err       = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  // The queue being loaded is visible in the same cycle so the first reply byte
  // can launch on the cycle after the strobe or read completion.
  assign qn_eff = load ? load_n : q_n;
  assign q0_eff = load ? load_b0 : q0;
  assign q1_eff = load ? load_b1 : q1;
  // One push every other cycle at most, so a late tx_full is always seen in time.
  assign push   = (qn_eff != 2'd0) && !tx_full && !tx_write_q;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state       <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      byte_cnt    <= '0;
      rd_cnt      <= '0;
      q_n         <= 2'd0;
      q0          <= '0;
      q1          <= '0;
      tx_write_q  <= 1'b0;
      tx_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_err_q <= err;
      if (rx_read) begin
        case (state)
          S_OP:    op_q    <= rx_data;
          S_ADDR:  addr_q  <= rx_data;
          S_DATA:  wdata_q <= rx_data;
          default: ;
        endcase
      end
      if (!in_frame || rx_read) begin
        byte_cnt <= '0;
      end else if (byte_cnt != BT_W'(BYTE_TIMEOUT)) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (state != S_WAIT_RD || reg_rd_valid) begin
        rd_cnt <= '0;
      end else if (rd_cnt != RT_W'(RD_TIMEOUT)) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      tx_write_q <= push;
      if (push) begin
        tx_data_q <= q0_eff;
        q0        <= q1_eff;
        q1        <= '0;
        q_n       <= qn_eff - 2'd1;
      end else begin
        q0        <= q0_eff;
        q1        <= q1_eff;
        q_n       <= qn_eff;
      end
    end
  end

  assign tx_write  = tx_write_q;
  assign tx_data   = tx_data_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = (state == S_EXEC_WR);
  assign reg_rd    = (state == S_EXEC_RD);
  assign frame_err = frame_err_q;
  assign busy      = (state != S_IDLE);

endmodule
